apb_master_arbiter: RTL and testbench



---
 rtl/apb_master_arbiter_pkg.sv | 30 +++
 rtl/apb_master_arbiter_if.sv | 28 ++
 rtl/apb_master_arbiter_rr.sv | 31 +++
 rtl/apb_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// rtl/apb_master_arbiter_pkg.sv - shared types, codes and address decode for the APB master arbiter
// Contents: state_t (FSM states), RESP_* response codes, slave region constants,
//           decode_psel() mapping addr[15:12] to the one-hot slave select.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int NUM_SLAVES = 5;
  localparam int REGION_LSB = 12;
  localparam int REGION_MSB = 15;
  localparam logic [3:0] REGION_LAST = 4'd4;

  // Region 0 is slave 1 (MSB of psel), region 4 is slave 5 (LSB); anything else decodes to 0.
  function automatic logic [NUM_SLAVES-1:0] decode_psel(input logic [3:0] region);
    if (region <= REGION_LAST) begin
      return NUM_SLAVES'(5'b10000 >> region);
    end
    return '0;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus bundle between the arbiter and the slave read-return mux
// Signals: paddr/pwrite/pwdata/psel/penable driven by master; prdata/pready/presp driven by slave side.
// Modports: master (arbiter), slave (read-return mux / bench).
interface apb_master_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]     paddr;
  logic                  pwrite;
  logic [DATA_W-1:0]     pwdata;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic [1:0]            presp;

  modport master (
    output paddr, pwrite, pwdata, psel, penable,
    input  prdata, pready, presp
  );

  modport slave (
    input  paddr, pwrite, pwdata, psel, penable,
    output prdata, pready, presp
  );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// rtl/apb_master_arbiter_rr.sv - combinational round-robin grant for NUM_REQ requesters
// Ports: req (in, NUM_REQ) requests; ptr (in, PTR_W) highest-priority index; gnt (out, NUM_REQ) one-hot grant.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan starting at ptr and wrapping; the first active request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB bus between NUM_REQ requesters
// Ports: clk, reset (sync, active-high); req_valid/req_write/req_addr/req_wdata in, req_ready out (one-hot accept);
//        rsp_valid (one-hot pulse), rsp_rdata, rsp_resp out; apb (master modport) to the five APB slaves.
// Option: APB_TIMEOUT_EN enables the ACCESS-phase timeout of TIMEOUT cycles.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  apb_master_arbiter_if.master      apb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr, grant, gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic [ADDR_W-1:0]     addr_q, gnt_addr;
  logic [DATA_W-1:0]     wdata_q, gnt_wdata;
  logic                  write_q, gnt_write;
  logic [NUM_SLAVES-1:0] sel_q, gnt_sel, psel_c;
  logic                  penable_c;
  logic                  accept;
  logic                  to_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign gnt_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign gnt_write = req_write[gnt_idx];
  assign gnt_sel   = decode_psel(gnt_addr[REGION_MSB:REGION_LSB]);
  assign accept    = (state == ST_IDLE) && (|req_valid);

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts ACCESS cycles without pready; restarts on every new ACCESS phase.
  always_ff @(posedge clk) begin
    if (reset || state != ST_ACCESS) to_cnt <= '0;
    else if (!apb.pready)            to_cnt <= to_cnt + 1'b1;
  end
  assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|req_valid) state_nxt = (gnt_sel != '0) ? ST_SETUP : ST_RESP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb.pready || to_expired) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Transfer latches and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      if (accept) begin
        grant   <= gnt_idx;
        addr_q  <= gnt_addr;
        wdata_q <= gnt_wdata;
        write_q <= gnt_write;
        sel_q   <= gnt_sel;
        if (gnt_sel == '0) begin
          rsp_rdata <= '0;
          rsp_resp  <= RESP_DECERR;
        end
      end
      if (state == ST_ACCESS) begin
        if (apb.pready) begin
          rsp_rdata <= write_q ? '0 : apb.prdata;
          rsp_resp  <= apb.presp;
        end else if (to_expired) begin
          rsp_rdata <= '0;
          rsp_resp  <= RESP_SLVERR;
        end
      end
      if (state == ST_RESP) begin
        rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Outputs; handshake strobes are held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    psel_c    = '0;
    penable_c = 1'b0;
    case (state)
      ST_IDLE:   if (!reset) req_ready = gnt;
      ST_SETUP:  psel_c = sel_q;
      ST_ACCESS: begin
        psel_c    = sel_q;
        penable_c = 1'b1;
      end
      ST_RESP:   if (!reset) rsp_valid[grant] = 1'b1;
      default:   ;
    endcase
  end

  assign apb.paddr   = addr_q;
  assign apb.pwrite  = write_q;
  assign apb.pwdata  = wdata_q;
  assign apb.psel    = psel_c;
  assign apb.penable = penable_c;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .apb       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester-side model state
  logic [1:0]  vld, wr;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  int          exp_ptr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave n (1..5) lives at region n-1 and owns psel bit (5-n).
  function automatic logic [4:0] exp_psel(input logic [31:0] a);
    int region;
    region = int'(a[15:12]);
    if (region < 5) return 5'b00001 << (4 - region);
    return 5'b00000;
  endfunction

  task automatic apply_reqs();
    req_valid = vld;
    req_write = wr;
    req_addr  = {ad[1], ad[0]};
    req_wdata = {wd[1], wd[0]};
  endtask

  task automatic new_req(input int r);
    logic [31:0] a;
    a        = $urandom;
    a[15:12] = 4'($urandom % 8);
    vld[r]   = 1'b1;
    wr[r]    = 1'($urandom % 2);
    ad[r]    = a;
    wd[r]    = $urandom;
  endtask

  // Arbitrate from idle, then follow the granted transfer to its response.
  task automatic run_one(input int fill_pct, input int waits, input logic [31:0] rd,
                         input logic [1:0] rs, output int winner);
    int w, tries, r;
    logic [4:0] sel;
    w = -1;
    tries = 0;
    winner = -1;
    while (w < 0) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (!vld[i] && int'($urandom % 100) < fill_pct) new_req(i);
      apply_reqs();
      #1;
      for (int i = 0; i < 2; i++) begin
        r = (exp_ptr + i) % 2;
        if (vld[r] && w < 0) w = r;
      end
      check("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
      check("idle_psel", bus.psel, 0);
      tries++;
      if (w < 0 && tries > 50) begin
        check("grant_wait", 0, 1);
        return;
      end
    end
    sel = exp_psel(ad[w]);
    if (sel == 5'b0) begin
      @(negedge clk); #1;
      check("decerr_valid", rsp_valid, 1 << w);
      check("decerr_resp", rsp_resp, 2'b11);
      check("decerr_rdata", rsp_rdata, 0);
      check("decerr_psel", bus.psel, 0);
    end else begin
      @(negedge clk); #1;
      check("setup_psel", bus.psel, sel);
      check("setup_penable", bus.penable, 0);
      check("setup_paddr", bus.paddr, ad[w]);
      check("setup_pwrite", bus.pwrite, wr[w]);
      check("setup_pwdata", bus.pwdata, wd[w]);
      check("setup_rsp_valid", rsp_valid, 0);
      bus.pready = 1'($urandom % 2);
      for (int k = 0; k <= waits; k++) begin
        @(negedge clk); #1;
        check("access_psel", bus.psel, sel);
        check("access_penable", bus.penable, 1);
        check("access_paddr", bus.paddr, ad[w]);
        check("access_pwdata", bus.pwdata, wd[w]);
        check("access_rsp_valid", rsp_valid, 0);
        check("access_req_ready", req_ready, 0);
        bus.pready = (k == waits);
        bus.prdata = (k == waits) ? rd : $urandom;
        bus.presp  = (k == waits) ? rs : 2'($urandom % 4);
      end
      @(negedge clk); #1;
      check("rsp_valid", rsp_valid, 1 << w);
      check("rsp_rdata", rsp_rdata, wr[w] ? 32'h0 : rd);
      check("rsp_resp", rsp_resp, rs);
      check("rsp_psel", bus.psel, 0);
      check("rsp_penable", bus.penable, 0);
      check("rsp_no_grant", req_ready, 0);
      bus.pready = 1'b0;
    end
    vld[w]  = 1'b0;
    exp_ptr = (w + 1) % 2;
    if (fill_pct > 0 && fill_pct < 100 && vld[1-w] && ($urandom % 5) == 0) vld[1-w] = 1'b0;
    winner = w;
  endtask

  initial begin
    int w, exp_alt;
    reset = 1'b1;
    vld = '0; wr = '0;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    apply_reqs();
    bus.pready = 1'b0; bus.prdata = '0; bus.presp = '0;
    exp_ptr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);

    vld = 2'b01; wr[0] = 1'b0; ad[0] = 32'h0000_2004;
    run_one(0, 0, 32'hCAFE_0001, 2'b00, w);
    vld = 2'b10; wr[1] = 1'b1; ad[1] = 32'h0000_4000; wd[1] = 32'hDEAD_BEEF;
    run_one(0, 3, $urandom, 2'b00, w);
    vld = 2'b01; wr[0] = 1'b0; ad[0] = 32'h0000_7000;
    run_one(0, 0, 32'h0, 2'b00, w);

    exp_alt = exp_ptr;
    for (int n = 0; n < 4; n++) begin
      run_one(100, int'($urandom % 3), $urandom, 2'($urandom % 4), w);
      check("alternate", w, exp_alt);
      exp_alt = 1 - exp_alt;
    end

    for (int n = 0; n < 40; n++)
      run_one(60, int'($urandom % 4), $urandom, 2'($urandom % 4), w);

    // Reset in the middle of an ACCESS wait
    @(negedge clk);
    vld = 2'b10; wr[1] = 1'b0; ad[1] = 32'h0000_1000;
    apply_reqs(); #1;
    check("pre_rst_grant", req_ready, 2'b10);
    @(negedge clk);
    bus.pready = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_penable", bus.penable, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    vld = 2'b00;
    apply_reqs();
    exp_ptr = 0;
    check("post_rst_psel", bus.psel, 0);
    check("post_rst_penable", bus.penable, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    new_req(0);
    new_req(1);
    run_one(0, 1, $urandom, 2'b00, w);
    check("post_rst_winner", w, 0);

`ifdef APB_TIMEOUT_EN
    @(negedge clk);
    vld = 2'b01; wr[0] = 1'b0; ad[0] = 32'h0000_3000;
    apply_reqs(); #1;
    check("to_grant", req_ready, 2'b01);
    @(negedge clk);
    bus.pready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      check("to_access", bus.penable, 1);
    end
    @(negedge clk); #1;
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_rsp_resp", rsp_resp, 2'b10);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", bus.psel, 0);
    vld = 2'b00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
